// File: rtl/serial_nibble_adder_ctrl.sv
// Multi-nibble adder built from one 4-bit slice, one nibble per clock, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub port (A-B via inverted B and carry-in of 1).
module serial_nibble_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 busy
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } opnd_t;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  opnd_t         op_r;
  logic          sub_r;
  logic          start_cin;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    slice;

`ifdef SERIAL_ADD_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sub_r <= 1'b0;
    else if (in_valid && in_ready)
      sub_r <= sub;
  end
  assign start_cin = sub;
`else
  assign sub_r     = 1'b0;
  assign start_cin = 1'b0;
`endif

  // Only this slice sits on the critical path; the index only steers the muxes.
  assign a_nib = op_r.a[4*idx +: 4];
  assign b_nib = op_r.b[4*idx +: 4] ^ {4{sub_r}};
  assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      op_r  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r.a <= a;
          op_r.b <= b;
          idx    <= '0;
          carry  <= start_cin;
          state  <= RUN;
        end
        RUN: begin
          sum[4*idx +: 4] <= slice[3:0];
          carry           <= slice[4];
          if (idx == LAST) begin
            c_out <= slice[4];
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// Bench for serial_nibble_adder_ctrl: NIBBLES=4/2/16 instances, random ops vs an arithmetic model.
module tb_serial_nibble_adder_ctrl;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv, ir, ov, co, bz, ordy, sb;
  logic [63:0] av [3];
  logic [63:0] bv [3];
  logic [63:0] sm [3];
  logic [15:0] s4;
  logic [7:0]  s2;
  logic [63:0] s16;

  int vec = 0;
  int err = 0;

  // model state: operation outstanding, cycles since accept, held result
  bit          pend [3];
  int          cnt  [3];
  logic [63:0] es   [3];
  logic        ec   [3];

  always #5 clk = ~clk;

  serial_nibble_adder_ctrl #(.NIBBLES(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][15:0]), .b(bv[0][15:0]),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sb[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s4), .c_out(co[0]), .busy(bz[0]));

  serial_nibble_adder_ctrl #(.NIBBLES(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sb[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s2), .c_out(co[1]), .busy(bz[1]));

  serial_nibble_adder_ctrl #(.NIBBLES(16)) u_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sb[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s16), .c_out(co[2]), .busy(bz[2]));

  assign sm[0] = {48'b0, s4};
  assign sm[1] = {56'b0, s2};
  assign sm[2] = s16;

  function automatic int nib(int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 16);
  endfunction

  // {carry, sum} of (A + B_eff + cin) over 4*n bits
  function automatic logic [64:0] ref_add(int n, logic [63:0] x, logic [63:0] y, logic s);
    logic [63:0] m;
    logic [64:0] f;
    m = (n >= 16) ? '1 : ((64'd1 << (4*n)) - 64'd1);
    f = {1'b0, x & m} + {1'b0, (s ? ~y : y) & m} + 65'(s);
    return {f[4*n], f[63:0] & m};
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    vec++;
    if (got !== want) begin
      err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic checker_loop();
    bit          eb, ev;
    logic [64:0] r;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          pend[i] = 1'b0; cnt[i] = 0; es[i] = '0; ec[i] = 1'b0;
        end else begin
          eb = pend[i] && (cnt[i] < nib(i));
          ev = pend[i] && (cnt[i] >= nib(i));
          vec++;
          if ({ir[i], ov[i], bz[i]} !== {!pend[i], ev, eb}) begin
            err++;
            $display("FAIL hs[%0d] t=%0t got rdy/val/busy=%b want %b", i, $time,
                     {ir[i], ov[i], bz[i]}, {!pend[i], ev, eb});
          end
          if (!eb) begin
            vec++;
            if ({co[i], sm[i]} !== {ec[i], es[i]}) begin
              err++;
              $display("FAIL result[%0d] t=%0t got c=%b s=%h want c=%b s=%h", i, $time,
                       co[i], sm[i], ec[i], es[i]);
            end
          end
          if (!pend[i]) begin
            if (iv[i]) begin
              r = ref_add(nib(i), av[i], bv[i], HAS_SUB ? sb[i] : 1'b0);
              pend[i] = 1'b1; cnt[i] = 0; es[i] = r[63:0]; ec[i] = r[64];
            end
          end else if (cnt[i] < nib(i)) begin
            cnt[i]++;
          end else if (ordy[i]) begin
            pend[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int i, input logic [63:0] a_i, input logic [63:0] b_i,
                        input logic s_i, input bit noise,
                        output logic [63:0] r, output logic c, output int lat, output int bc);
    int t;
    int k;
    bit hs;
    t = 0;
    while (!ir[i] && t < 50) begin step(); t++; end
    chk("in_ready_before_op", 64'(ir[i]), 64'd1);
    iv[i] = 1'b1; av[i] = a_i; bv[i] = b_i; sb[i] = s_i;
    ordy[i] = noise ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    bc = int'(bz[i]);
    lat = 0;
    while (!ov[i] && lat < 40) begin
      if (noise) begin
        iv[i] = 1'($urandom_range(0, 1));
        av[i] = {$urandom, $urandom}; bv[i] = {$urandom, $urandom};
        sb[i] = 1'($urandom_range(0, 1)); ordy[i] = 1'($urandom_range(0, 1));
      end else begin
        iv[i] = 1'b0;
      end
      step();
      lat++;
      bc += int'(bz[i]);
    end
    r = sm[i];
    c = co[i];
    chk("latency", 64'(lat), 64'(nib(i)));
    k = 0;
    do begin
      hs = noise ? (k >= 4 || $urandom_range(0, 1) == 1) : 1'b1;
      ordy[i] = hs;
      iv[i] = hs ? 1'b0 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      step();
      k++;
    end while (!hs);
    ordy[i] = 1'b0;
    iv[i] = 1'b0;
  endtask

  task automatic rand_ops(int i, int n);
    logic [63:0] x, y, r;
    logic [64:0] e;
    logic        s, c;
    int          lat, bc;
    for (int k = 0; k < n; k++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) begin x = '1; y = 64'd1; end
      s = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op(i, x, y, s, 1'b1, r, c, lat, bc);
      e = ref_add(nib(i), x, y, s);
      chk("rand_result", {c, r}, e[64:0] & 65'h1_FFFF_FFFF_FFFF_FFFF);
    end
  endtask

  initial begin
    logic [63:0] r;
    logic        c;
    int          lat, bc, t;

    rst_n = 1'b0; iv = '0; ordy = '0; sb = '0;
    for (int i = 0; i < 3; i++) begin av[i] = '0; bv[i] = '0; end
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("reset_hs", 64'({ir[i], ov[i], bz[i]}), 64'b100);
      chk("reset_sum", sm[i], 64'd0);
      chk("reset_cout", 64'(co[i]), 64'd0);
    end
    fork checker_loop(); join_none
    step(); step();
    rst_n = 1'b1;
    step();

    run_op(0, 64'h1234, 64'h0FCD, 1'b0, 1'b0, r, c, lat, bc);
    chk("basic_sum", r, 64'h2201);
    chk("basic_cout", 64'(c), 64'd0);
    chk("basic_latency", 64'(lat), 64'd4);

    run_op(0, 64'hFFFF, 64'h0001, 1'b0, 1'b0, r, c, lat, bc);
    chk("ripple_sum", r, 64'h0000);
    chk("ripple_cout", 64'(c), 64'd1);
    chk("ripple_busy_cycles", 64'(bc), 64'd4);

    // backpressure: offer a second operand pair throughout DONE
    iv[0] = 1'b1; av[0] = 64'h5555; bv[0] = 64'h1111; sb[0] = 1'b0; ordy[0] = 1'b0;
    step();
    av[0] = 64'h0AAA; bv[0] = 64'h0BBB;
    t = 0;
    while (!ov[0] && t < 40) begin step(); t++; end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(ov[0]), 64'd1);
      chk("bp_ready", 64'(ir[0]), 64'd0);
      chk("bp_sum", sm[0], 64'h6666);
      chk("bp_cout", 64'(co[0]), 64'd0);
      step();
    end
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    chk("bp_ready_after_hs", 64'(ir[0]), 64'd1);
    chk("bp_busy_after_hs", 64'(bz[0]), 64'd0);
    step();
    iv[0] = 1'b0;
    chk("bp_second_accept", 64'(bz[0]), 64'd1);
    t = 0;
    while (!ov[0] && t < 40) begin step(); t++; end
    chk("bp_second_sum", sm[0], 64'h1665);
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;

    if (HAS_SUB) begin
      run_op(0, 64'h1234, 64'h0235, 1'b1, 1'b0, r, c, lat, bc);
      chk("sub_sum", r, 64'h0FFF);
      chk("sub_cout", 64'(c), 64'd1);
      run_op(0, 64'h0001, 64'h0002, 1'b1, 1'b0, r, c, lat, bc);
      chk("sub_borrow_sum", r, 64'hFFFF);
      chk("sub_borrow_cout", 64'(c), 64'd0);
    end

    // reset in the second RUN cycle
    iv[0] = 1'b1; av[0] = 64'h8888; bv[0] = 64'h8888; sb[0] = 1'b0;
    step();
    iv[0] = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_hs", 64'({ir[0], ov[0], bz[0]}), 64'b100);
    chk("midrst_sum", sm[0], 64'd0);
    chk("midrst_cout", 64'(co[0]), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    run_op(0, 64'h0003, 64'h0004, 1'b0, 1'b0, r, c, lat, bc);
    chk("post_rst_sum", r, 64'h0007);
    chk("post_rst_cout", 64'(c), 64'd0);

    rand_ops(0, 300);
    rand_ops(1, 1000);
    rand_ops(2, 1000);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
